sp256k: RTL and testbench



---
 rtl/sp256k.sv | 48 ++++
 tb/tb_sp256k.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sp256k.sv
// Behavioural 16384 x 16 single-port SRAM with nibble write masks,
// a registered read port and standby/sleep/power-off controls.
module sp256k (
    input  logic        CK,
    input  logic        reset,
    input  logic [13:0] AD,
    input  logic [15:0] DI,
    input  logic [3:0]  MASKWE,
    input  logic        WE,
    input  logic        CS,
    input  logic        STDBY,
    input  logic        SLEEP,
    input  logic        PWROFF_N,
    output logic [15:0] DO
);

    logic [15:0] mem [0:16383];
    logic [15:0] do_reg;
    logic        acc;

    assign acc = CS & ~STDBY & ~SLEEP & PWROFF_N;

    // Storage has no reset: a write coinciding with reset still lands.
    always_ff @(posedge CK) begin
        if (acc && WE) begin
            for (int i = 0; i < 4; i++) begin
                if (MASKWE[i]) begin
                    mem[AD][4*i +: 4] <= DI[4*i +: 4];
                end
            end
        end
    end

    // Cleared while sleeping or powered off so DO stays 0 after exit
    // until the next read edge.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            do_reg <= '0;
        end else if (!PWROFF_N || SLEEP) begin
            do_reg <= '0;
        end else if (acc && !WE) begin
            do_reg <= mem[AD];
        end
    end

    assign DO = (PWROFF_N && !SLEEP) ? do_reg : '0;

endmodule

// File: tb/tb_sp256k.sv
// Randomised scoreboard bench for sp256k: a word/nibble-level memory model
// predicts DO for every cycle, a monitor compares after each rising edge.
module tb_sp256k;

    logic        CK = 1'b0;
    logic        reset;
    logic [13:0] AD;
    logic [15:0] DI;
    logic [3:0]  MASKWE;
    logic        WE;
    logic        CS;
    logic        STDBY;
    logic        SLEEP;
    logic        PWROFF_N;
    logic [15:0] DO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          chk;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_val   [int];
    logic [3:0]  mem_known [int];
    logic [15:0] model_do;
    bit          model_do_known;
    logic [13:0] addr_pool [8];

    sp256k dut (
        .CK(CK),
        .reset(reset),
        .AD(AD),
        .DI(DI),
        .MASKWE(MASKWE),
        .WE(WE),
        .CS(CS),
        .STDBY(STDBY),
        .SLEEP(SLEEP),
        .PWROFF_N(PWROFF_N),
        .DO(DO)
    );

    always #5 CK = ~CK;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus; the model predicts DO as seen just after the edge.
    task automatic apply_stimulus(input bit rst, input bit cs, input bit we,
                                  input bit stdby, input bit sleep, input bit pwr,
                                  input logic [13:0] ad, input logic [15:0] di,
                                  input logic [3:0] mask);
        exp_t        e;
        bit          acc;
        int          a;
        logic [15:0] w;
        logic [3:0]  k;
        @(negedge CK);
        reset    = rst;
        CS       = cs;
        WE       = we;
        STDBY    = stdby;
        SLEEP    = sleep;
        PWROFF_N = pwr;
        AD       = ad;
        DI       = di;
        MASKWE   = mask;
        a   = int'(ad);
        acc = cs && !stdby && !sleep && pwr;
        if (!pwr) begin
            mem_val.delete();
            mem_known.delete();
        end else if (acc && we) begin
            w = mem_val.exists(a) ? mem_val[a] : 16'h0000;
            k = mem_known.exists(a) ? mem_known[a] : 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    w[4*i +: 4] = di[4*i +: 4];
                    k[i] = 1'b1;
                end
            end
            mem_val[a]   = w;
            mem_known[a] = k;
        end
        if (rst || !pwr || sleep) begin
            model_do       = 16'h0000;
            model_do_known = 1'b1;
        end else if (acc && !we) begin
            if (mem_known.exists(a) && mem_known[a] == 4'hF) begin
                model_do       = mem_val[a];
                model_do_known = 1'b1;
            end else begin
                model_do_known = 1'b0;
            end
        end
        e.chk = model_do_known;
        e.val = model_do;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [13:0] ad, input logic [15:0] di, input logic [3:0] mask);
        apply_stimulus(0, 1, 1, 0, 0, 1, ad, di, mask);
    endtask

    task automatic rd(input logic [13:0] ad);
        apply_stimulus(0, 1, 0, 0, 0, 1, ad, 16'h0000, 4'h0);
    endtask

    // Monitor: one expectation per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check_output("do_scoreboard", DO, e.val);
                end
            end
        end
    end

    initial begin
        logic [13:0] ad;
        reset = 0; CS = 0; WE = 0; STDBY = 0; SLEEP = 0; PWROFF_N = 1;
        AD = '0; DI = '0; MASKWE = '0;
        model_do = 16'h0000;
        model_do_known = 1'b0;
        addr_pool[0] = 14'h0000; addr_pool[1] = 14'h3FFF; addr_pool[2] = 14'h0005;
        addr_pool[3] = 14'h0007; addr_pool[4] = 14'h0064; addr_pool[5] = 14'h0001;
        addr_pool[6] = 14'h2AAA; addr_pool[7] = 14'h1555;

        // Asynchronous reset between edges
        #12;
        reset = 1;
        #1;
        check_output("reset_async", DO, 16'h0000);
        model_do = 16'h0000;
        model_do_known = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0, 16'h0, 4'h0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0, 16'h0, 4'h0);

        wr(14'h0000, 16'hA5C3, 4'hF);
        wr(14'h3FFF, 16'h1234, 4'hF);
        rd(14'h0000);
        rd(14'h3FFF);

        wr(14'h0005, 16'hFFFF, 4'hF);
        wr(14'h0005, 16'h0000, 4'h3);
        rd(14'h0005);
        wr(14'h0005, 16'hABCD, 4'hC);
        rd(14'h0005);
        wr(14'h0005, 16'h1234, 4'h0);
        rd(14'h0005);

        wr(14'h0007, 16'h3333, 4'hF);
        apply_stimulus(0, 0, 1, 0, 0, 1, 14'h0007, 16'h1111, 4'hF);
        apply_stimulus(0, 1, 1, 1, 0, 1, 14'h0007, 16'h2222, 4'hF);
        rd(14'h0007);
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0007, 16'h0, 4'h0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0000, 16'h0, 4'h0);

        wr(14'h0064, 16'h5A5A, 4'hF);
        rd(14'h0064);
        apply_stimulus(0, 1, 0, 0, 1, 1, 14'h0064, 16'h0, 4'h0);
        apply_stimulus(0, 1, 1, 0, 1, 1, 14'h0064, 16'hFFFF, 4'hF);
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0064, 16'h0, 4'h0);
        rd(14'h0064);

        wr(14'h0001, 16'h0F0F, 4'hF);
        rd(14'h0001);
        wr(14'h0001, 16'h9999, 4'hF);
        rd(14'h0001);

        apply_stimulus(0, 1, 0, 0, 0, 0, 14'h0001, 16'h0, 4'h0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0001, 16'h0, 4'h0);

        for (int n = 0; n < 600; n++) begin
            ad = ($urandom_range(0, 9) == 0) ? 14'($urandom) : addr_pool[$urandom_range(0, 7)];
            apply_stimulus($urandom_range(0, 99) < 2,
                           $urandom_range(0, 99) < 85,
                           $urandom_range(0, 1) == 1,
                           $urandom_range(0, 99) < 10,
                           $urandom_range(0, 99) < 5,
                           !($urandom_range(0, 99) < 2),
                           ad, 16'($urandom), 4'($urandom));
        end

        apply_stimulus(0, 0, 0, 0, 0, 1, 14'h0, 16'h0, 4'h0);
        repeat (3) @(posedge CK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
